dmem_wbuf: RTL and testbench
============================

Name: dmem_wbuf

Overview:
- Posted-write buffer between the CPU data port and the single-port data memory (dmem), which has a combinational read and a write on the clock edge.
- CPU stores are queued and drained into dmem on cycles when the CPU is not loading, so loads get the port first.
- Loads see the latest value: data comes from the youngest matching buffered store, otherwise from dmem.

Parameters:
- DEPTH, 4, number of buffer entries (power of 2, ≥2)
- AW, 30, word-address width; covers address bits [31:2]
- DW, 32, data width

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_wr  in  1  store request this cycle
- cpu_rd  in  1  load request this cycle
- cpu_addr  in  [31:2]  word address of the request
- cpu_writedata  in  DW  store data
- cpu_readdata  out  DW  load data (combinational)
- cpu_stall  out  1  CPU must hold its request and retry next cycle
- flush  in  1  drain request; held until empty=1
- empty  out  1  no buffered entries
- mem_wr  out  1  dmem write enable
- mem_addr  out  [31:2]  dmem word address
- mem_writedata  out  DW  dmem write data
- mem_readdata  in  DW  dmem read data (combinational)

Behaviour:
- Storage: circular FIFO of {addr, data} with head/tail pointers and a count register. Invariant: at most one entry per address.
- Reset (asynchronous, reset_n=0):
  - head=tail=count=0, all entries invalid.
  - empty=1, cpu_stall=0, mem_wr=0.
  - Buffered stores are discarded, including on reset mid-operation.
- pop = !empty && !cpu_rd.
  - On pop: mem_wr=1, mem_addr/mem_writedata = head entry.
  - Head advances at the clock edge, so each drain takes 1 cycle.
  - Otherwise mem_wr=0 and mem_addr=cpu_addr.
- Load (cpu_rd=1):
  - mem_addr=cpu_addr, no pop.
  - cpu_readdata = data of the matching valid entry if one exists, else mem_readdata.
  - Zero-cycle latency; a load never stalls.
- Store (cpu_wr=1), evaluated in this order:
  1. Merge: a valid entry with the same address, excluding the head when pop=1, has its data overwritten. No slot is used, so a merge is accepted even when full.
  2. Push: written at tail if count<DEPTH, or if pop=1 (simultaneous push and pop, count unchanged).
  3. Otherwise cpu_stall=1 and nothing changes.
- Store to the head address while the head pops: a new entry is pushed and the head still drains its old data. dmem ends with the new data one drain later.
- cpu_wr and cpu_rd together:
  - The read gets the port and the write is pushed or merged.
  - If full with no merge, cpu_stall=1.
  - Forwarding uses pre-write buffer contents, so a load returns the old value.
- Flush: cpu_stall = flush && !empty. Pops continue every cycle because cpu_rd is ignored for the pop decision while flushing. empty asserts combinationally when count==0.
- Count arithmetic: next = count + push − pop, range 0..DEPTH. Pointers wrap modulo DEPTH.
- Outputs: cpu_readdata, cpu_stall, empty and the mem_* outputs are combinational from registers and inputs. All state updates on the rising edge of clk.

Decomposition:
- Package dmem_wbuf_pkg holds:
  - typedef wbuf_entry_t = struct {valid, addr[AW-1:0], data[DW-1:0]}
  - localparam PTRW = $clog2(DEPTH)
- Sub-module wbuf_cam: combinational address match over all entries.
  - Inputs: the entries and a query address.
  - Outputs: hit, one-hot index, data.
  - Instantiated once for write merge and once for read forwarding.

Test Plan:
1. Reset mid-drain: push 3 stores, hold cpu_rd=1, pulse reset_n=0 → empty=1, mem_wr=0. A later load of those addresses returns the original dmem contents.
2. Forwarding: store 0xDEADBEEF to word 0x10 with cpu_rd=1 held the next cycle → cpu_readdata=0xDEADBEEF the same cycle, mem_wr=0, and dmem[0x10] is unchanged until cpu_rd drops.
3. Merge when full: fill 4 entries (words 1–4) with cpu_rd=1, then store 0x55 to word 3 with cpu_rd=1 → cpu_stall=0, count stays 4, dmem[3]=0x55 after drain.
4. Full stall: 4 entries, cpu_rd=1 and cpu_wr to new word 9 → cpu_stall=1. Drop cpu_rd → push and pop in the same cycle, count stays 4, word 9 drains last.
5. Head collision: head=word 5 data 0xA, store 0xB to word 5 while popping → dmem[5]=0xA then 0xB over the next 2 drains; a final load of word 5 returns 0xB.
6. Flush: 3 entries, assert flush → cpu_stall=1 for exactly 3 cycles, empty=1 in cycle 4, dmem holds all 3 values in FIFO order.

Source files
------------

// File: rtl/dmem_wbuf_pkg.sv
// Shared types for the dmem posted-write buffer.
// Entry layout, default sizes and pointer width.
package dmem_wbuf_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 30;
  localparam int WB_DW    = 32;
  localparam int PTRW     = $clog2(WB_DEPTH);

  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_cam.sv
// Combinational address match over all buffer entries.
// Ports: ents, addr in; hit, one-hot idx and matching data out.
module wbuf_cam
  import dmem_wbuf_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  wbuf_entry_t      ents [DEPTH],
  input  logic [WB_AW-1:0] addr,
  output logic             hit,
  output logic [DEPTH-1:0] idx,
  output logic [WB_DW-1:0] data
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < DEPTH; i++)
      idx[i] = ents[i].valid && (ents[i].addr == addr);
  end

  assign hit = |idx;

  // At most one entry per address, so an OR-mux is enough.
  always_comb begin
    data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (idx[i]) data = data | ents[i].data;
  end

endmodule

// File: rtl/dmem_wbuf.sv
// Posted-write buffer between CPU data port and dmem.
// Ports: cpu_* request side, flush/empty, mem_* dmem side.
module dmem_wbuf
  import dmem_wbuf_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_wr,
  input  logic          cpu_rd,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_writedata,
  output logic [DW-1:0] cpu_readdata,
  output logic          cpu_stall,
  input  logic          flush,
  output logic          empty,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_writedata,
  input  logic [DW-1:0] mem_readdata
);

  localparam int PW = $clog2(DEPTH);

  wbuf_entry_t ents  [DEPTH];
  wbuf_entry_t ments [DEPTH];

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;
  logic             is_empty;
  logic             full;
  logic             pop;
  logic             fl_stall;
  logic             wr_ok;
  logic             merge;
  logic             push;
  logic             m_hit;
  logic             r_hit;
  logic [DEPTH-1:0] m_idx;
  logic [DEPTH-1:0] r_idx;
  logic [DW-1:0]    m_data;
  logic [DW-1:0]    r_data;
  logic             unused;

  assign is_empty = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign fl_stall = flush && !is_empty;
  // While flushing, loads do not block the drain.
  assign pop      = !is_empty && (!cpu_rd || flush);

  // The draining head cannot absorb a merge.
  always_comb begin
    ments = ents;
    if (pop) ments[head].valid = 1'b0;
  end

  wbuf_cam #(.DEPTH(DEPTH)) u_wcam (
    .ents (ments),
    .addr (cpu_addr),
    .hit  (m_hit),
    .idx  (m_idx),
    .data (m_data)
  );

  wbuf_cam #(.DEPTH(DEPTH)) u_rcam (
    .ents (ents),
    .addr (cpu_addr),
    .hit  (r_hit),
    .idx  (r_idx),
    .data (r_data)
  );

  assign unused = ^{m_data, r_idx};

  assign wr_ok = cpu_wr && !fl_stall
              && (m_hit || !full || pop);
  assign merge = wr_ok && m_hit;
  assign push  = wr_ok && !m_hit;

  assign cpu_stall = fl_stall
                  || (cpu_wr && !m_hit && full && !pop);

  assign empty         = is_empty;
  assign mem_wr        = pop;
  assign mem_addr      = pop ? ents[head].addr : cpu_addr;
  assign mem_writedata = ents[head].data;
  assign cpu_readdata  = r_hit ? r_data : mem_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        ents[i] <= '0;
    end else begin
      if (pop) begin
        ents[head].valid <= 1'b0;
        head <= head + PW'(1);
      end
      for (int i = 0; i < DEPTH; i++)
        if (merge && m_idx[i])
          ents[i].data <= cpu_writedata;
      // Placed after the pop so a full push+pop wins the slot.
      if (push) begin
        ents[tail] <= '{1'b1, cpu_addr, cpu_writedata};
        tail <= tail + PW'(1);
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Scoreboard bench for dmem_wbuf with a queue-based model.
// Drives directed and random traffic against a dmem array.
module tb_dmem_wbuf;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        flush = 1'b0;
  logic [29:0] cpu_addr = '0;
  logic [31:0] cpu_writedata = '0;
  logic [31:0] cpu_readdata;
  logic        cpu_stall;
  logic        empty;
  logic        mem_wr;
  logic [29:0] mem_addr;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  logic [31:0] dmem [32];
  bit          dm_ready = 0;

  always #5 clk = ~clk;

  dmem_wbuf dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_wr        (cpu_wr),
    .cpu_rd        (cpu_rd),
    .cpu_addr      (cpu_addr),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .cpu_stall     (cpu_stall),
    .flush         (flush),
    .empty         (empty),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata)
  );

  assign mem_readdata = dmem[mem_addr[4:0]];

  always @(posedge clk) begin
    if (!dm_ready) begin
      for (int i = 0; i < 32; i++)
        dmem[i] <= 32'hC0DE_0000 + i;
    end else if (mem_wr) begin
      dmem[mem_addr[4:0]] <= mem_writedata;
    end
  end

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } st_t;

  typedef struct {
    bit          chk_rd;
    logic [31:0] rd;
    logic        stall;
    logic        emp;
    logic        mwr;
    logic [29:0] maddr;
  } exp_t;

  st_t         q[$];
  exp_t        sb[$];
  logic [31:0] ref_mem [32];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // One CPU cycle: drive inputs, predict outputs, update model.
  task automatic step(input logic wr, input logic rd,
                      input logic fl, input logic [29:0] a,
                      input logic [31:0] d);
    exp_t e;
    int   hit;
    bit   pop;
    bit   stall;
    @(posedge clk);
    #1;
    cpu_wr = wr;
    cpu_rd = rd;
    flush = fl;
    cpu_addr = a;
    cpu_writedata = d;
    pop = (q.size() > 0) && (!rd || fl);
    hit = -1;
    for (int i = (pop ? 1 : 0); i < q.size(); i++)
      if (q[i].a == a) hit = i;
    stall = (fl && q.size() > 0)
         || (wr && hit < 0 && q.size() == D && !pop);
    e.chk_rd = rd && !(fl && q.size() > 0);
    e.rd = ref_mem[a[4:0]];
    for (int i = 0; i < q.size(); i++)
      if (q[i].a == a) e.rd = q[i].d;
    e.stall = stall;
    e.emp = (q.size() == 0);
    e.mwr = pop;
    e.maddr = pop ? q[0].a : a;
    sb.push_back(e);
    if (wr && !stall) begin
      if (hit >= 0) q[hit].d = d;
      else q.push_back('{a, d});
    end
    if (pop) begin
      ref_mem[q[0].a[4:0]] = q[0].d;
      void'(q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_rd) chk("rdata", cpu_readdata, e.rd);
      chk("stall", {31'b0, cpu_stall}, {31'b0, e.stall});
      chk("empty", {31'b0, empty}, {31'b0, e.emp});
      chk("mem_wr", {31'b0, mem_wr}, {31'b0, e.mwr});
      chk("mem_addr", {2'b0, mem_addr}, {2'b0, e.maddr});
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++)
      ref_mem[i] = 32'hC0DE_0000 + i;
    #2;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    #4;
    dm_ready = 1;
    reset_n = 1'b1;

    // forwarding while loads hold the port
    step(1, 0, 0, 30'h10, 32'hDEAD_BEEF);
    step(0, 1, 0, 30'h10, '0);
    step(0, 1, 0, 30'h10, '0);
    chk("fwd_dmem_hold", dmem[16], 32'hC0DE_0010);
    idle(2);
    chk("fwd_dmem_drain", dmem[16], 32'hDEAD_BEEF);

    // merge into a full buffer
    for (int i = 1; i <= 4; i++)
      step(1, 1, 0, 30'(i), 32'h100 + i);
    step(1, 1, 0, 30'd3, 32'h55);
    idle(5);
    chk("merge_full", dmem[3], 32'h55);

    // full stall, then push+pop
    for (int i = 1; i <= 4; i++)
      step(1, 1, 0, 30'(i), 32'h200 + i);
    step(1, 1, 0, 30'd9, 32'h99);
    step(1, 0, 0, 30'd9, 32'h99);
    idle(5);
    chk("stall_last", dmem[9], 32'h99);

    // store to the draining head address
    step(1, 0, 0, 30'd5, 32'hA);
    step(1, 0, 0, 30'd5, 32'hB);
    step(0, 0, 0, '0, '0);
    chk("head_old", dmem[5], 32'hA);
    step(0, 0, 0, '0, '0);
    chk("head_new", dmem[5], 32'hB);
    step(0, 1, 0, 30'd5, '0);

    // flush three entries
    for (int i = 6; i <= 8; i++)
      step(1, 1, 0, 30'(i), 32'h300 + i);
    n = 0;
    while (q.size() > 0 && n < 10) begin
      step(0, 0, 1, '0, '0);
      n++;
    end
    step(0, 0, 1, '0, '0);
    chk("flush_cycles", n, 32'd3);
    idle(1);
    chk("flush_w8", dmem[8], 32'h308);

    // random traffic
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 19) == 0),
           30'($urandom_range(0, 15)),
           $urandom);

    // reset while loads block the drain
    for (int i = 20; i <= 22; i++)
      step(1, 1, 0, 30'(i), 32'h400 + i);
    @(posedge clk);
    #1;
    cpu_wr = 1'b0;
    flush = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_empty", {31'b0, empty}, 32'd1);
    chk("mid_rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("mid_rst_stall", {31'b0, cpu_stall}, 32'd0);
    q.delete();
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 20; i <= 22; i++)
      step(0, 1, 0, 30'(i), '0);

    for (int k = 0; k < 200; k++)
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 5),
           1'($urandom_range(0, 19) == 0),
           30'($urandom_range(0, 15)),
           $urandom);

    n = 0;
    while (q.size() > 0 && n < 20) begin
      step(0, 0, 1, '0, '0);
      n++;
    end
    step(0, 0, 1, '0, '0);
    idle(1);
    @(negedge clk);
    for (int i = 0; i < 32; i++)
      chk($sformatf("dmem[%0d]", i), dmem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
